// File: rtl/baud_gen_frac.sv
// baud_gen_frac: fractional-N oversample/mid/baud tick generator with glitch-free divisor reload
module baud_gen_frac #(
  parameter int DIV_W = 12,
  parameter int FRAC_W = 4,
  parameter int OVERSAMPLE = 16,
  parameter int DEFAULT_INT = 13,
  parameter int DEFAULT_FRAC = 9
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              sync_clear,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  output logic              load_ack,
  output logic              os_tick,
  output logic              mid_tick,
  output logic              baud_tick
);
  localparam int OS_W = $clog2(OVERSAMPLE);
  logic [DIV_W:0] cnt, period;
  logic [DIV_W-1:0] act_int, sh_int, new_int;
  logic [FRAC_W-1:0] act_frac, sh_frac, acc, eff_frac;
  logic [FRAC_W:0] sum;
  logic [OS_W-1:0] os_cnt;
  logic stretch, pending, wrap, apply, os_last, os_mid;
  assign period = {1'b0, act_int} + (DIV_W+1)'(stretch);
  // >= rather than == so a shorter divisor applied while idle cannot skip the terminal count
  assign wrap = enable & ~sync_clear & (cnt + 1'b1 >= period);
  assign apply = pending & ~div_load & (wrap | ~enable | sync_clear);
  assign new_int = sh_int < DIV_W'(2) ? DIV_W'(2) : sh_int;
  assign eff_frac = apply ? sh_frac : act_frac;
  assign sum = {1'b0, acc} + {1'b0, eff_frac};
  assign os_last = os_cnt == OS_W'(OVERSAMPLE-1);
  assign os_mid = os_cnt == OS_W'(OVERSAMPLE/2-1);
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      os_cnt <= '0;
      acc <= '0;
      stretch <= 1'b0;
      act_int <= DIV_W'(DEFAULT_INT);
      act_frac <= FRAC_W'(DEFAULT_FRAC);
      sh_int <= '0;
      sh_frac <= '0;
      pending <= 1'b0;
      os_tick <= 1'b0;
      mid_tick <= 1'b0;
      baud_tick <= 1'b0;
      load_ack <= 1'b0;
    end else begin
      os_tick <= wrap;
      mid_tick <= wrap & os_mid;
      baud_tick <= wrap & os_last;
      load_ack <= apply;
      if (sync_clear) begin
        cnt <= '0;
        os_cnt <= '0;
        acc <= '0;
        stretch <= 1'b0;
      end else if (wrap) begin
        cnt <= '0;
        acc <= sum[FRAC_W-1:0];
        stretch <= sum[FRAC_W];
        os_cnt <= os_last ? '0 : os_cnt + 1'b1;
      end else if (enable) begin
        cnt <= cnt + 1'b1;
      end
      if (apply) begin
        act_int <= new_int;
        act_frac <= sh_frac;
        pending <= 1'b0;
      end
      if (div_load) begin
        sh_int <= div_int;
        sh_frac <= div_frac;
        pending <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_baud_gen_frac.sv
// tb_baud_gen_frac: random and directed stimulus against a period/elapsed-time reference model, scoreboard-checked
module tb_baud_gen_frac;
  logic sys_clk = 1'b0;
  logic reset, enable, sync_clear, div_load;
  logic [11:0] div_int;
  logic [3:0] div_frac;
  logic load_ack, os_tick, mid_tick, baud_tick;
  typedef struct {int t; logic os; logic mid; logic baud; logic ack;} ev_t;
  ev_t q[$];
  ev_t e;
  int checks = 0, errors = 0, cyc = 0;
  int sp_os = 0, sp_baud = 0, last_os = -1, last_baud = -1;
  int m_int, m_frac, s_int, s_frac, m_pend, m_el, m_st, m_acc, m_osc;
  baud_gen_frac dut (
    .sys_clk(sys_clk), .reset(reset), .enable(enable), .sync_clear(sync_clear),
    .div_int(div_int), .div_frac(div_frac), .div_load(div_load), .load_ack(load_ack),
    .os_tick(os_tick), .mid_tick(mid_tick), .baud_tick(baud_tick)
  );
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;
  task automatic model_reset();
    m_int = 13; m_frac = 9; s_int = 0; s_frac = 0; m_pend = 0;
    m_el = 0; m_st = 0; m_acc = 0; m_osc = 0;
  endtask
  // Model: an os period lasts m_int (+1 when the previous fraction add carried) enabled cycles
  task automatic drive(input bit en, input bit sc, input bit ld, input int di, input int df);
    bit fire, app;
    int f;
    ev_t x;
    @(negedge sys_clk);
    enable = en; sync_clear = sc; div_load = ld; div_int = 12'(di); div_frac = 4'(df);
    fire = en && !sc && (m_el + 1 >= m_int + m_st);
    app = (m_pend != 0) && !ld && (fire || !en || sc);
    x.t = cyc + 1; x.os = fire; x.mid = fire && m_osc == 7; x.baud = fire && m_osc == 15; x.ack = app;
    if (x.os || x.ack) q.push_back(x);
    if (sc) begin
      m_el = 0; m_osc = 0; m_acc = 0; m_st = 0;
    end else if (fire) begin
      f = app ? s_frac : m_frac;
      m_st = (m_acc + f >= 16) ? 1 : 0;
      m_acc = (m_acc + f) % 16;
      m_osc = (m_osc + 1) % 16;
      m_el = 0;
    end else if (en) m_el++;
    if (app) begin
      m_int = s_int < 2 ? 2 : s_int; m_frac = s_frac; m_pend = 0;
    end
    if (ld) begin
      s_int = di; s_frac = df; m_pend = 1;
    end
  endtask
  task automatic set_sp(input int o, input int b);
    @(posedge sys_clk);
    sp_os = o; sp_baud = b; last_os = -1; last_baud = -1;
  endtask
  task automatic chk_zero(input string nm);
    checks++;
    if ({os_tick, mid_tick, baud_tick, load_ack} != 4'b0) begin
      errors++;
      $display("FAIL %s outputs=%b want 0000", nm, {os_tick, mid_tick, baud_tick, load_ack});
    end
  endtask
  initial forever begin
    @(negedge sys_clk);
    while (q.size() != 0 && q[0].t < cyc) begin
      e = q.pop_front(); checks++; errors++;
      $display("FAIL missing_event t=%0d got none want os%b ack%b", e.t, e.os, e.ack);
    end
    if (q.size() != 0 && q[0].t == cyc) begin
      e = q.pop_front(); checks++;
      if ({os_tick, mid_tick, baud_tick, load_ack} != {e.os, e.mid, e.baud, e.ack}) begin
        errors++;
        $display("FAIL event t=%0d got os%b mid%b baud%b ack%b want os%b mid%b baud%b ack%b",
          cyc, os_tick, mid_tick, baud_tick, load_ack, e.os, e.mid, e.baud, e.ack);
      end
    end else if (os_tick | mid_tick | baud_tick | load_ack) begin
      checks++; errors++;
      $display("FAIL unexpected t=%0d got os%b mid%b baud%b ack%b want none",
        cyc, os_tick, mid_tick, baud_tick, load_ack);
    end
    if (os_tick) begin
      if (sp_os != 0 && last_os >= 0) begin
        checks++;
        if (cyc - last_os != sp_os) begin
          errors++; $display("FAIL os_spacing t=%0d got %0d want %0d", cyc, cyc - last_os, sp_os);
        end
      end
      last_os = cyc;
    end
    if (baud_tick) begin
      if (sp_baud != 0 && last_baud >= 0) begin
        checks++;
        if (cyc - last_baud != sp_baud) begin
          errors++; $display("FAIL baud_spacing t=%0d got %0d want %0d", cyc, cyc - last_baud, sp_baud);
        end
      end
      last_baud = cyc;
    end
  end
  initial begin
    reset = 1'b1; enable = 1'b0; sync_clear = 1'b0; div_load = 1'b0; div_int = '0; div_frac = '0;
    model_reset();
    repeat (2) @(posedge sys_clk);
    #1 chk_zero("reset_state");
    @(negedge sys_clk);
    reset = 1'b0;
    set_sp(0, 217);
    repeat (700) drive(1, 0, 0, 0, 0);
    set_sp(0, 0);
    drive(0, 0, 1, 4, 0);
    drive(0, 0, 0, 0, 0);
    set_sp(4, 64);
    repeat (200) drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 40 && (m_el + 4 != m_int + m_st); i++) drive(1, 0, 0, 0, 0);
    drive(1, 0, 1, 20, 0);
    set_sp(20, 0);
    repeat (70) drive(1, 0, 0, 0, 0);
    set_sp(0, 0);
    repeat (7) drive(1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    set_sp(20, 320);
    repeat (700) drive(1, 0, 0, 0, 0);
    set_sp(0, 0);
    drive(1, 0, 1, 0, 0);
    repeat (30) drive(1, 0, 0, 0, 0);
    set_sp(2, 32);
    repeat (40) drive(1, 0, 0, 0, 0);
    set_sp(0, 0);
    repeat (10) drive(0, 0, 0, 0, 0);
    set_sp(2, 32);
    repeat (80) drive(1, 0, 0, 0, 0);
    set_sp(0, 0);
    drive(1, 0, 1, 7, 3);
    @(posedge sys_clk);
    #2 reset = 1'b1;
    #1 chk_zero("reset_midop");
    while (q.size() != 0 && q[$].t >= cyc) void'(q.pop_back());
    model_reset();
    enable = 1'b0; sync_clear = 1'b0; div_load = 1'b0;
    @(negedge sys_clk);
    reset = 1'b0;
    set_sp(0, 217);
    repeat (500) drive(1, 0, 0, 0, 0);
    set_sp(0, 0);
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 60) == 0, $urandom_range(0, 40) == 0,
            $urandom_range(0, 9), $urandom_range(0, 15));
    repeat (5) drive(0, 0, 0, 0, 0);
    @(negedge sys_clk);
    checks++;
    if (q.size() != 0) begin
      errors++; $display("FAIL queue_drain got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
